router_out_fifo: RTL and testbench



---
 rtl/router_out_fifo_if.sv | 22 ++
 rtl/router_out_fifo.sv | 107 ++++++++++
 tb/tb_router_out_fifo.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/router_out_fifo_if.sv
// Byte-stream handshake between the register stage/controller, the output FIFO and the destination reader.
interface router_out_fifo_if #(
    parameter int WIDTH = 8
);
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] data_out;

    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  full, empty, data_out
    );

    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output full, empty, data_out
    );
endinterface

// File: rtl/router_out_fifo.sv
// Per-destination router output FIFO with header-length tracking that releases data_out between packets.
// Optional macro ROUTER_OUT_FIFO_TRISTATE_EN: released/reset data_out is driven to Z instead of 0.
module router_out_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   soft_reset,
    router_out_fifo_if.slave       bus
);
    localparam int PTR_W = ADDR_W + 1;
    localparam int CNT_W = WIDTH - 1;

    logic [WIDTH:0]   r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_data_out;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_en;
    logic             w_rd_en;
    logic [WIDTH:0]   w_rd_entry;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                        (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_wr_en    = bus.write_enb && !w_full;
    assign w_rd_en    = bus.read_enb && !w_empty;
    assign w_rd_entry = r_mem[r_rd_ptr[ADDR_W-1:0]];

    assign bus.full   = w_full;
    assign bus.empty  = w_empty;

    // Storage, pointers, packet length counter and registered read data.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_data_out <= {WIDTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {(WIDTH+1){1'b0}};
            end
        end else if (soft_reset) begin
            // Only the header flags must be scrubbed so stale headers cannot reload the count.
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_data_out <= {WIDTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i][WIDTH] <= 1'b0;
            end
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr[ADDR_W-1:0]] <= {bus.lfd_state, bus.data_in};
                r_wr_ptr                    <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end

            if (w_rd_en) begin
                r_data_out <= w_rd_entry[WIDTH-1:0];
                r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                // Header carries payload length in its upper bits; +1 covers the parity byte.
                if (w_rd_entry[WIDTH]) begin
                    r_count <= {1'b0, w_rd_entry[WIDTH-1:2]} + CNT_W'(1);
                end else if (r_count != {CNT_W{1'b0}}) begin
                    r_count <= r_count - CNT_W'(1);
                end else begin
                    r_count <= r_count;
                end
            end else if (r_count == {CNT_W{1'b0}}) begin
                r_data_out <= {WIDTH{1'b0}};
            end else begin
                r_data_out <= r_data_out;
            end
        end
    end

`ifdef ROUTER_OUT_FIFO_TRISTATE_EN
    logic r_oe;

    // Output enable follows the same release rule as r_data_out.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_oe <= 1'b0;
        end else if (soft_reset) begin
            r_oe <= 1'b0;
        end else if (w_rd_en) begin
            r_oe <= 1'b1;
        end else if (r_count == {CNT_W{1'b0}}) begin
            r_oe <= 1'b0;
        end else begin
            r_oe <= r_oe;
        end
    end

    assign bus.data_out = r_oe ? r_data_out : {WIDTH{1'bz}};
`else
    assign bus.data_out = r_data_out;
`endif

endmodule

// File: tb/tb_router_out_fifo.sv
// Self-checking bench for router_out_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_router_out_fifo;
    logic clock      = 1'b0;
    logic resetn     = 1'b0;
    logic soft_reset = 1'b0;

    router_out_fifo_if #(.WIDTH(8)) bus ();

    router_out_fifo #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    always #5 clock = ~clock;

`ifdef ROUTER_OUT_FIFO_TRISTATE_EN
    localparam logic [7:0] REL = 8'hzz;
`else
    localparam logic [7:0] REL = 8'h00;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [8:0] q[$];
    int         cnt = 0;
    logic [7:0] exp_out = REL;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare just after.
    task automatic cycle(input bit rstn, input bit srst, input bit we, input bit re,
                         input bit lfd, input logic [7:0] din);
        bit         rd_ok;
        bit         wr_ok;
        logic [8:0] e;
        @(negedge clock);
        resetn        = rstn;
        soft_reset    = srst;
        bus.write_enb = we;
        bus.read_enb  = re;
        bus.lfd_state = lfd;
        bus.data_in   = din;
        @(posedge clock);
        if (!rstn || srst) begin
            q.delete();
            cnt     = 0;
            exp_out = REL;
        end else begin
            rd_ok = re && (q.size() != 0);
            wr_ok = we && (q.size() < 16);
            if (rd_ok) begin
                e       = q.pop_front();
                exp_out = e[7:0];
                if (e[8])         cnt = int'(e[7:2]) + 1;
                else if (cnt > 0) cnt = cnt - 1;
            end else if (cnt == 0) begin
                exp_out = REL;
            end
            if (wr_ok) q.push_back({lfd, din});
        end
        #1;
        check("empty", 16'(bus.empty), 16'(q.size() == 0));
        check("full", 16'(bus.full), 16'(q.size() == 16));
        check("data_out", 16'(bus.data_out), 16'(exp_out));
    endtask

    task automatic wr(input bit lfd, input logic [7:0] din);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, lfd, din);
    endtask

    task automatic rd();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic srst();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] pkt [5];

    initial begin
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = 8'h00;

        // Reset
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
        check("rst_empty", 16'(bus.empty), 16'h0001);
        check("rst_full", 16'(bus.full), 16'h0000);
`ifndef ROUTER_OUT_FIFO_TRISTATE_EN
        check("rst_data", 16'(bus.data_out), 16'h0000);
`endif

        // Soft reset with 5 entries stored
        for (int i = 0; i < 5; i++) wr(1'b0, 8'(8'h40 + i));
        check("pre_srst_empty", 16'(bus.empty), 16'h0000);
        srst();
        check("srst_empty", 16'(bus.empty), 16'h0001);
        rd();
        check("srst_rd_ignored", 16'(bus.empty), 16'h0001);

        // Packet pass-through
        pkt[0] = 8'h0D; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3; pkt[4] = 8'h0F;
        wr(1'b1, pkt[0]);
        for (int i = 1; i < 5; i++) wr(1'b0, pkt[i]);
        for (int i = 0; i < 5; i++) begin
            rd();
            check("pkt_byte", 16'(bus.data_out), 16'(pkt[i]));
        end
        idle();
`ifndef ROUTER_OUT_FIFO_TRISTATE_EN
        check("pkt_release", 16'(bus.data_out), 16'h0000);
`endif

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) wr(1'b0, 8'(i));
        check("fill_full", 16'(bus.full), 16'h0001);
        wr(1'b0, 8'hFF);
        check("ovf_full", 16'(bus.full), 16'h0001);
        for (int i = 0; i < 16; i++) begin
            rd();
            check("ovf_rd", 16'(bus.data_out), 16'(i));
        end
        check("drain_empty", 16'(bus.empty), 16'h0001);

        // Simultaneous read+write while full
        for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h30 + i));
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
        check("sim_data", 16'(bus.data_out), 16'h0030);
        check("sim_full", 16'(bus.full), 16'h0000);
        for (int i = 1; i < 16; i++) begin
            rd();
            check("sim_drain", 16'(bus.data_out), 16'(8'h30 + i));
        end
        check("sim_empty", 16'(bus.empty), 16'h0001);

        // Wrap across index 15 -> 0
        srst();
        for (int i = 0; i < 12; i++) wr(1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 12; i++) rd();
        for (int i = 0; i < 8; i++) wr(1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 8; i++) begin
            rd();
            check("wrap_rd", 16'(bus.data_out), 16'(8'h20 + i));
        end
        check("wrap_empty", 16'(bus.empty), 16'h0001);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(1'b1, ($urandom_range(99) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  ($urandom_range(3) == 0), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
